// File: rtl/ibuffer.sv
// ---------------------------------------------------------------------------
// ibuffer -- instruction buffer between fetch and decode.
//
// Takes one fetch group per handshake. A group has IPF slots, a slot-valid
// mask that is contiguous from slot 0, the PC of slot 0 and a predicted next
// PC for each slot. The valid slots are packed into a circular FIFO of
// single-instruction entries. Each cycle the DEQ_WIDTH oldest entries are
// shown to decode in program order. A backend flush empties the buffer.
//
// Handshakes (valid/ready):
//   fetch  -> buffer : the group transfers on a clock edge where fe_valid_i
//                      and fe_ready_o are both high. fe_ready_o depends only
//                      on registered state, so fetch can sample it before it
//                      raises fe_valid_i. A group is taken whole or not at all.
//   buffer -> decode : de_valid_o is a prefix mask of occupied lanes. When
//                      de_ready_i is high and lane 0 is valid, every valid
//                      lane transfers on that edge. de_ready_i is ignored when
//                      the buffer is empty.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fe_valid_i / fe_ready_o    fetch group handshake
//   fe_pc_i                    PC of slot 0
//   fe_data_i                  IPF slot instructions, slot i at [i*ILEN +: ILEN]
//   fe_slot_valid_i            slot-valid mask, contiguous from slot 0
//   fe_pred_npc_i              per-slot predicted next PC
//   de_valid_o                 lane valid, prefix-contiguous
//   de_instr_o / de_pc_o       lane instruction and PC
//   de_pred_npc_o              lane predicted next PC
//   de_ready_i                 decode takes every valid lane this cycle
//   flush_i                    backend flush; takes priority over all traffic
//   count_o                    number of occupied entries (debug/perf)
// ---------------------------------------------------------------------------
module ibuffer #(
    parameter int PLEN      = 32,
    parameter int ILEN      = 32,
    parameter int IPF       = 4,
    parameter int DEPTH     = 16,
    parameter int DEQ_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fe_valid_i,
    output logic                          fe_ready_o,
    input  logic [PLEN-1:0]               fe_pc_i,
    input  logic [IPF*ILEN-1:0]           fe_data_i,
    input  logic [IPF-1:0]                fe_slot_valid_i,
    input  logic [IPF*PLEN-1:0]           fe_pred_npc_i,
    output logic [DEQ_WIDTH-1:0]          de_valid_o,
    output logic [DEQ_WIDTH*ILEN-1:0]     de_instr_o,
    output logic [DEQ_WIDTH*PLEN-1:0]     de_pc_o,
    output logic [DEQ_WIDTH*PLEN-1:0]     de_pred_npc_o,
    input  logic                          de_ready_i,
    input  logic                          flush_i,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Largest occupancy at which a full group still fits.
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - IPF);
    localparam logic [CW-1:0] DEQ_MAX   = CW'(DEQ_WIDTH);

    logic [ILEN-1:0] mem_instr [DEPTH];
    logic [PLEN-1:0] mem_pc    [DEPTH];
    logic [PLEN-1:0] mem_npc   [DEPTH];

    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] n_enq;
    logic [CW-1:0] n_deq;
    logic          enq_fire;
    logic          deq_fire;

    assign fe_ready_o = (count_q <= READY_MAX);
    assign enq_fire   = fe_valid_i && fe_ready_o;
    assign deq_fire   = de_ready_i && de_valid_o[0];
    assign count_o    = count_q;

    // The mask is a prefix, so its popcount is also the index bound of the
    // slots to write.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < IPF; i++) begin
            n_enq = n_enq + CW'(fe_slot_valid_i[i]);
        end
    end

    assign n_deq = (count_q < DEQ_MAX) ? count_q : DEQ_MAX;

    // Pointer and occupancy state. Pointers are AW bits so they wrap
    // modulo DEPTH on their own; count_q needs the extra bit for "full".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                tail_q <= tail_q + AW'(n_enq);
            end
            if (deq_fire) begin
                head_q <= head_q + AW'(n_deq);
            end
            count_q <= count_q + (enq_fire ? n_enq : CW'(0))
                               - (deq_fire ? n_deq : CW'(0));
        end
    end

    // Entry storage carries no reset; only entries below count_q are ever
    // presented to decode.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush_i) begin
            for (int i = 0; i < IPF; i++) begin
                if (CW'(i) < n_enq) begin
                    mem_instr[tail_q + AW'(i)] <= fe_data_i[i*ILEN +: ILEN];
                    mem_pc[tail_q + AW'(i)]    <= fe_pc_i + PLEN'(4 * i);
                    mem_npc[tail_q + AW'(i)]   <= fe_pred_npc_i[i*PLEN +: PLEN];
                end
            end
        end
    end

    // Lane k shows entry head+k straight from registered state; there is no
    // fetch-to-decode bypass.
    always_comb begin
        de_valid_o    = '0;
        de_instr_o    = '0;
        de_pc_o       = '0;
        de_pred_npc_o = '0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            de_valid_o[k]                  = (CW'(k) < count_q);
            de_instr_o[k*ILEN +: ILEN]     = mem_instr[head_q + AW'(k)];
            de_pc_o[k*PLEN +: PLEN]        = mem_pc[head_q + AW'(k)];
            de_pred_npc_o[k*PLEN +: PLEN]  = mem_npc[head_q + AW'(k)];
        end
    end

endmodule

// File: tb/tb_ibuffer.sv
// ---------------------------------------------------------------------------
// tb_ibuffer -- self-checking bench for ibuffer (IPF=4, DEPTH=16, DEQ_WIDTH=4).
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge before new inputs are driven. Expected entries {instr, pc, npc} go into
// exp_q when a group is predicted to fire. They are popped and compared as
// decode consumes lanes.
// ---------------------------------------------------------------------------
module tb_ibuffer;

    localparam int PLEN  = 32;
    localparam int ILEN  = 32;
    localparam int IPF   = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 4;
    localparam int W     = ILEN + 2 * PLEN;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   fe_valid_i = 1'b0;
    logic                   fe_ready_o;
    logic [PLEN-1:0]        fe_pc_i = '0;
    logic [IPF*ILEN-1:0]    fe_data_i = '0;
    logic [IPF-1:0]         fe_slot_valid_i = '0;
    logic [IPF*PLEN-1:0]    fe_pred_npc_i = '0;
    logic [DW-1:0]          de_valid_o;
    logic [DW*ILEN-1:0]     de_instr_o;
    logic [DW*PLEN-1:0]     de_pc_o;
    logic [DW*PLEN-1:0]     de_pred_npc_o;
    logic                   de_ready_i = 1'b0;
    logic                   flush_i = 1'b0;
    logic [4:0]             count_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  instr_tag = 32'h0000_1000;

    ibuffer #(
        .PLEN(PLEN), .ILEN(ILEN), .IPF(IPF), .DEPTH(DEPTH), .DEQ_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fe_valid_i(fe_valid_i),
        .fe_ready_o(fe_ready_o),
        .fe_pc_i(fe_pc_i),
        .fe_data_i(fe_data_i),
        .fe_slot_valid_i(fe_slot_valid_i),
        .fe_pred_npc_i(fe_pred_npc_i),
        .de_valid_o(de_valid_o),
        .de_instr_o(de_instr_o),
        .de_pc_o(de_pc_o),
        .de_pred_npc_o(de_pred_npc_o),
        .de_ready_i(de_ready_i),
        .flush_i(flush_i),
        .count_o(count_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] lane(input int k);
        return {de_instr_o[k*ILEN +: ILEN], de_pc_o[k*PLEN +: PLEN],
                de_pred_npc_o[k*PLEN +: PLEN]};
    endfunction

    // Present a group on the fetch port with fresh instruction tags and
    // random predicted next PCs.
    task automatic drive_group(input logic [31:0] pc, input logic [3:0] mask);
        fe_valid_i      = 1'b1;
        fe_pc_i         = pc;
        fe_slot_valid_i = mask;
        for (int i = 0; i < IPF; i++) begin
            fe_data_i[i*ILEN +: ILEN]     = instr_tag;
            instr_tag                     = instr_tag + 1;
            fe_pred_npc_i[i*PLEN +: PLEN] = $urandom();
        end
    endtask

    // Scoreboard push of the group currently on the fetch port.
    task automatic push_expected();
        for (int i = 0; i < IPF; i++) begin
            if (fe_slot_valid_i[i]) begin
                exp_q.push_back({fe_data_i[i*ILEN +: ILEN], fe_pc_i + 32'(4 * i),
                                 fe_pred_npc_i[i*PLEN +: PLEN]});
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL rst_count: got %0d expected 0", count_o); else pass_cnt++;
        total_cnt++; if (fe_ready_o !== 1'b1) $display("FAIL rst_fe_ready: got %b expected 1", fe_ready_o); else pass_cnt++;
        total_cnt++; if (de_valid_o !== 4'b0000) $display("FAIL rst_de_valid: got %b expected 0000", de_valid_o); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_group();
        logic [W-1:0] e;
        @(negedge clk);
        drive_group(32'h8000_0000, 4'b1111);
        push_expected();
        @(negedge clk);
        fe_valid_i = 1'b0;
        total_cnt++; if (count_o !== 5'd4) $display("FAIL t1_count: got %0d expected 4", count_o); else pass_cnt++;
        total_cnt++; if (de_valid_o !== 4'b1111) $display("FAIL t1_de_valid: got %b expected 1111", de_valid_o); else pass_cnt++;
        total_cnt++; if (de_pc_o[3*PLEN +: PLEN] !== 32'h8000_000C) $display("FAIL t1_lane3_pc: got %h expected 8000000c", de_pc_o[3*PLEN +: PLEN]); else pass_cnt++;
        de_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            total_cnt++; if (lane(k) !== e) $display("FAIL t1_lane%0d: got %h expected %h", k, lane(k), e); else pass_cnt++;
        end
        @(negedge clk);
        de_ready_i = 1'b0;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t1_count_after: got %0d expected 0", count_o); else pass_cnt++;
        total_cnt++; if (de_valid_o !== 4'b0000) $display("FAIL t1_de_valid_after: got %b expected 0000", de_valid_o); else pass_cnt++;
    endtask

    task automatic test_partial_group();
        logic [W-1:0] e;
        @(negedge clk);
        drive_group(32'h8000_0010, 4'b0011);
        fe_pred_npc_i[1*PLEN +: PLEN] = 32'h8000_0100;
        push_expected();
        @(negedge clk);
        fe_valid_i = 1'b0;
        total_cnt++; if (count_o !== 5'd2) $display("FAIL t2_count: got %0d expected 2", count_o); else pass_cnt++;
        total_cnt++; if (de_valid_o !== 4'b0011) $display("FAIL t2_de_valid: got %b expected 0011", de_valid_o); else pass_cnt++;
        total_cnt++; if (de_pc_o[PLEN +: PLEN] !== 32'h8000_0014) $display("FAIL t2_lane1_pc: got %h expected 80000014", de_pc_o[PLEN +: PLEN]); else pass_cnt++;
        total_cnt++; if (de_pred_npc_o[PLEN +: PLEN] !== 32'h8000_0100) $display("FAIL t2_lane1_npc: got %h expected 80000100", de_pred_npc_o[PLEN +: PLEN]); else pass_cnt++;
        de_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            total_cnt++; if (lane(k) !== e) $display("FAIL t2_lane%0d: got %h expected %h", k, lane(k), e); else pass_cnt++;
        end
        @(negedge clk);
        // de_ready with nothing valid must be ignored.
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t2_count_after: got %0d expected 0", count_o); else pass_cnt++;
        @(negedge clk);
        de_ready_i = 1'b0;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t2_empty_ready: got %0d expected 0", count_o); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        int n;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            total_cnt++; if (fe_ready_o !== 1'b1) $display("FAIL t3_ready_g%0d: got %b expected 1", g, fe_ready_o); else pass_cnt++;
            drive_group(32'h8000_1000 + 32'(16 * g), 4'b1111);
            push_expected();
        end
        @(negedge clk);
        total_cnt++; if (count_o !== 5'd16) $display("FAIL t3_count_full: got %0d expected 16", count_o); else pass_cnt++;
        total_cnt++; if (fe_ready_o !== 1'b0) $display("FAIL t3_ready_full: got %b expected 0", fe_ready_o); else pass_cnt++;
        drive_group(32'h8000_2000, 4'b1111);
        @(negedge clk);
        total_cnt++; if (count_o !== 5'd16) $display("FAIL t3_held: got %0d expected 16", count_o); else pass_cnt++;
        total_cnt++; if (fe_ready_o !== 1'b0) $display("FAIL t3_ready_held: got %b expected 0", fe_ready_o); else pass_cnt++;
        de_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            total_cnt++; if (lane(k) !== e) $display("FAIL t3_lane%0d: got %h expected %h", k, lane(k), e); else pass_cnt++;
        end
        @(negedge clk);
        de_ready_i = 1'b0;
        total_cnt++; if (count_o !== 5'd12) $display("FAIL t3_count_12: got %0d expected 12", count_o); else pass_cnt++;
        total_cnt++; if (fe_ready_o !== 1'b1) $display("FAIL t3_ready_12: got %b expected 1", fe_ready_o); else pass_cnt++;
        // The held group is accepted on the coming edge.
        push_expected();
        @(negedge clk);
        fe_valid_i = 1'b0;
        for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
            total_cnt++; if (count_o !== 5'(exp_q.size())) $display("FAIL t3_drain_count: got %0d expected %0d", count_o, exp_q.size()); else pass_cnt++;
            de_ready_i = 1'b1;
            n = (exp_q.size() < DW) ? exp_q.size() : DW;
            for (int k = 0; k < n; k++) begin
                e = exp_q.pop_front();
                total_cnt++; if (lane(k) !== e || de_valid_o[k] !== 1'b1) $display("FAIL t3_drain_lane%0d: got %h expected %h", k, lane(k), e); else pass_cnt++;
            end
            @(negedge clk);
        end
        de_ready_i = 1'b0;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t3_drained: got %0d expected 0", count_o); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [W-1:0] e;
        logic [31:0]  pc_next;
        logic         exp_ready;
        int n;
        int sent;
        int cyc;
        pc_next = 32'h8000_7000;
        sent = 0;
        cyc = 0;
        while ((sent < 10 || exp_q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            fe_valid_i = 1'b0;
            de_ready_i = 1'b0;
            exp_ready = ((DEPTH - exp_q.size()) >= IPF);
            total_cnt++; if (count_o !== 5'(exp_q.size()) || count_o > 5'd16) $display("FAIL t4_count: got %0d expected %0d", count_o, exp_q.size()); else pass_cnt++;
            total_cnt++; if (fe_ready_o !== exp_ready) $display("FAIL t4_fe_ready: got %b expected %b", fe_ready_o, exp_ready); else pass_cnt++;
            if (exp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                de_ready_i = 1'b1;
                n = (exp_q.size() < DW) ? exp_q.size() : DW;
                for (int k = 0; k < n; k++) begin
                    e = exp_q.pop_front();
                    total_cnt++; if (lane(k) !== e || de_valid_o[k] !== 1'b1) $display("FAIL t4_lane%0d: got %h expected %h", k, lane(k), e); else pass_cnt++;
                end
            end
            if (sent < 10 && exp_ready) begin
                drive_group(pc_next, 4'b0111);
                push_expected();
                pc_next = pc_next + 32'd12;
                sent++;
            end
        end
        @(negedge clk);
        fe_valid_i = 1'b0;
        de_ready_i = 1'b0;
        total_cnt++; if (cyc >= 200) $display("FAIL t4_timeout: got %0d cycles expected under 200", cyc); else pass_cnt++;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t4_final_count: got %0d expected 0", count_o); else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [W-1:0] e;
        @(negedge clk);
        drive_group(32'h8000_3000, 4'b1111);
        push_expected();
        @(negedge clk);
        drive_group(32'h8000_3010, 4'b1111);
        push_expected();
        @(negedge clk);
        drive_group(32'h8000_3020, 4'b0001);
        push_expected();
        @(negedge clk);
        total_cnt++; if (count_o !== 5'd9) $display("FAIL t5_count9: got %0d expected 9", count_o); else pass_cnt++;
        flush_i    = 1'b1;
        de_ready_i = 1'b1;
        drive_group(32'h8000_4000, 4'b1111);
        exp_q.delete();
        #1;
        total_cnt++; if (de_valid_o !== 4'b1111) $display("FAIL t5_valid_in_flush: got %b expected 1111", de_valid_o); else pass_cnt++;
        @(negedge clk);
        flush_i    = 1'b0;
        de_ready_i = 1'b0;
        fe_valid_i = 1'b0;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t5_count: got %0d expected 0", count_o); else pass_cnt++;
        total_cnt++; if (de_valid_o !== 4'b0000) $display("FAIL t5_de_valid: got %b expected 0000", de_valid_o); else pass_cnt++;
        total_cnt++; if (fe_ready_o !== 1'b1) $display("FAIL t5_fe_ready: got %b expected 1", fe_ready_o); else pass_cnt++;
        drive_group(32'h8000_5000, 4'b0011);
        push_expected();
        @(negedge clk);
        fe_valid_i = 1'b0;
        total_cnt++; if (count_o !== 5'd2) $display("FAIL t5_count_new: got %0d expected 2", count_o); else pass_cnt++;
        de_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            total_cnt++; if (lane(k) !== e) $display("FAIL t5_lane%0d: got %h expected %h", k, lane(k), e); else pass_cnt++;
        end
        @(negedge clk);
        de_ready_i = 1'b0;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t5_count_end: got %0d expected 0", count_o); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [W-1:0] e;
        @(negedge clk);
        drive_group(32'h8000_6000, 4'b1111);
        push_expected();
        @(negedge clk);
        fe_valid_i = 1'b0;
        total_cnt++; if (count_o !== 5'd4) $display("FAIL t6_count_pre: got %0d expected 4", count_o); else pass_cnt++;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t6_count_rst: got %0d expected 0", count_o); else pass_cnt++;
        total_cnt++; if (de_valid_o !== 4'b0000) $display("FAIL t6_valid_rst: got %b expected 0000", de_valid_o); else pass_cnt++;
        total_cnt++; if (fe_ready_o !== 1'b1) $display("FAIL t6_ready_rst: got %b expected 1", fe_ready_o); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_group(32'h8000_0000, 4'b1111);
        push_expected();
        @(negedge clk);
        fe_valid_i = 1'b0;
        total_cnt++; if (count_o !== 5'd4) $display("FAIL t6_count_post: got %0d expected 4", count_o); else pass_cnt++;
        total_cnt++; if (de_pc_o[0 +: PLEN] !== 32'h8000_0000) $display("FAIL t6_lane0_pc: got %h expected 80000000", de_pc_o[0 +: PLEN]); else pass_cnt++;
        de_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            total_cnt++; if (lane(k) !== e) $display("FAIL t6_lane%0d: got %h expected %h", k, lane(k), e); else pass_cnt++;
        end
        @(negedge clk);
        de_ready_i = 1'b0;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL t6_count_end: got %0d expected 0", count_o); else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_full_group();
        test_partial_group();
        test_backpressure();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
